ign_scheduler: RTL
==================

Name: ign_scheduler

Overview:
Angle-based ignition scheduler that drives the per-cylinder coil outputs inside efi_main. It receives the current crank angle from the crank decoder and holds a per-channel dwell-start/fire angle table. Its configuration port is written from the SPI register file. For each channel it asserts the coil output at the dwell angle and releases it (spark) at the fire angle, with a hardware over-dwell cutoff that protects the coils.

Parameters:
N_CH, 8, number of ignition channels
ANGLE_W, 12, crank angle width; 0.25 deg/LSB, valid range 0..2879 (720 deg)
DWELL_W, 20, width of the per-channel dwell timer
MAX_DWELL, 500000, over-dwell limit in clk cycles (10 ms at 50 MHz)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
synced  in  1  crank decoder has position lock
angle_tick  in  1  one-cycle strobe: angle has a new value this cycle
angle  in  ANGLE_W  current crank angle, valid when angle_tick=1
cfg_we  in  1  config write strobe
cfg_ch  in  $clog2(N_CH)  channel being written
cfg_sel  in  2  0=dwell angle, 1=fire angle, 2=enable (cfg_wdata[0]), 3=ignored
cfg_wdata  in  ANGLE_W  write data
ovd_clr  in  1  clears all overdwell flags
ign  out  N_CH  coil drive, 1=dwelling (charging)
overdwell  out  N_CH  sticky per-channel over-dwell fault
commit_pending  out  1  shadow table differs from active table and awaits commit

Behaviour:
- Reset (async, reset_n=0): ign=0, overdwell=0, commit_pending=0. All shadow/active dwell and fire angles are 0, all enables are 0, all channels are in IDLE, all timers are 0.
- Config writes go to the shadow table only. A write sets commit_pending=1 on the following cycle. A write with cfg_sel=3 is ignored and does not set commit_pending.
- Commit copies shadow to active and clears commit_pending. Commit occurs:
  - when synced=1, on the cycle where angle_tick=1 and angle=0;
  - when synced=0, on every cycle.
- A write in the same cycle as a commit lands in the shadow table after the copy. That write stays pending (commit_pending=1).
- Per-channel FSM, IDLE <-> DWELL. All transitions are evaluated in the cycle where the condition holds; ign is registered, so it changes exactly 1 clk later.
  - IDLE -> DWELL: synced=1 & enable=1 & angle_tick & angle==dwell_angle & dwell_angle!=fire_angle. The dwell timer is cleared to 0 on entry.
  - DWELL -> IDLE (spark): angle_tick & angle==fire_angle.
  - DWELL -> IDLE (over-dwell): timer reaches MAX_DWELL-1. This sets the overdwell bit. ign is therefore high for exactly MAX_DWELL cycles.
  - DWELL -> IDLE (abort): synced falls to 0, or a commit writes enable=0 for this channel. The output drops; no flag is set.
  - If the fire match and the timer limit occur in the same cycle, the fire match wins and overdwell is not set.
  - A dwell-angle match while already in DWELL is ignored.
- Boundary conditions:
  - dwell_angle==fire_angle disables the channel; it never enters DWELL.
  - A fire angle that is never reached (>=2880) relies on the over-dwell cutoff.
  - Dwell across the 720-deg wrap (dwell_angle>fire_angle) is legal. A commit at angle 0 does not disturb an in-progress dwell unless it disables the channel.
  - Equality compare only: angles skipped by the decoder produce no event.
- The dwell timer saturates at MAX_DWELL-1 and counts only in DWELL.
- overdwell bits are sticky until ovd_clr=1. If ovd_clr and a new over-dwell occur in the same cycle, the set wins.
- Channels are independent. Any combination of channels may switch in the same cycle.

Test Plan:
- Channel 0 configured dwell=100, fire=200, enable=1 while synced=0 (immediate commit). Then synced=1, sweep angle 0..2879 with a tick every 4 clk -> ign[0] rises 1 clk after the angle=100 tick and falls 1 clk after the angle=200 tick; commit_pending=0 throughout.
- Channel 3 configured dwell=2800, fire=40, synced, sweeping -> ign[3] high from 2800 through the wrap, low after angle 40, in every cycle.
- Channel 1 configured dwell=500, fire=3000 (never reached), MAX_DWELL=1000 -> ign[1] high exactly 1000 clk, overdwell[1]=1 and stays set. ovd_clr pulse -> overdwell[1]=0.
- While synced, rewrite channel 0 fire=300 mid-cycle -> commit_pending=1. The current cycle still fires at 200. After the angle=0 tick commit_pending=0, and the next cycle fires at 300.
- Channel 2 dwelling; synced drops to 0 -> ign[2]=0 next clk, overdwell[2] stays 0. Assert reset_n=0 mid-dwell on all channels -> ign=0 immediately and the table reads back as disabled (no ign activity after release).
- Channel 4 configured dwell=fire=600 -> ign[4] never asserts over a full sweep.

Source files
------------

// File: rtl/ign_scheduler.sv
// Angle-based ignition scheduler: per-channel dwell/fire angle table with
// shadow/active commit at TDC and a hardware over-dwell cutoff.
module ign_scheduler #(
    parameter int N_CH      = 8,
    parameter int ANGLE_W   = 12,
    parameter int DWELL_W   = 20,
    parameter int MAX_DWELL = 500000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    synced,
    input  logic                    angle_tick,
    input  logic [ANGLE_W-1:0]      angle,
    input  logic                    cfg_we,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [1:0]              cfg_sel,
    input  logic [ANGLE_W-1:0]      cfg_wdata,
    input  logic                    ovd_clr,
    output logic [N_CH-1:0]         ign,
    output logic [N_CH-1:0]         overdwell,
    output logic                    commit_pending
);

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    localparam logic [DWELL_W-1:0] LIM = DWELL_W'(MAX_DWELL - 1);

    logic [ANGLE_W-1:0] sh_dwell  [N_CH];
    logic [ANGLE_W-1:0] sh_fire   [N_CH];
    logic [ANGLE_W-1:0] act_dwell [N_CH];
    logic [ANGLE_W-1:0] act_fire  [N_CH];
    logic [N_CH-1:0]    sh_en;
    logic [N_CH-1:0]    act_en;

    state_t             state_q [N_CH];
    state_t             state_d [N_CH];
    logic [DWELL_W-1:0] timer_q [N_CH];
    logic [DWELL_W-1:0] timer_d [N_CH];
    logic [N_CH-1:0]    ovd_set;
    logic [N_CH-1:0]    ovd_q;
    logic               pend_q;

    logic commit;
    logic cfg_hit;

    // Unsynced: the table tracks writes continuously; synced: only at TDC.
    assign commit  = synced ? (angle_tick && angle == '0) : 1'b1;
    assign cfg_hit = cfg_we && (cfg_sel != 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_dwell  <= '{default: '0};
            sh_fire   <= '{default: '0};
            act_dwell <= '{default: '0};
            act_fire  <= '{default: '0};
            sh_en     <= '0;
            act_en    <= '0;
            pend_q    <= 1'b0;
        end else begin
            if (commit) begin
                act_dwell <= sh_dwell;
                act_fire  <= sh_fire;
                act_en    <= sh_en;
            end
            if (cfg_we) begin
                unique case (cfg_sel)
                    2'd0:    sh_dwell[cfg_ch] <= cfg_wdata;
                    2'd1:    sh_fire[cfg_ch]  <= cfg_wdata;
                    2'd2:    sh_en[cfg_ch]    <= cfg_wdata[0];
                    default: ;
                endcase
            end
            if (cfg_hit) begin
                pend_q <= 1'b1;
            end else if (commit) begin
                pend_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ovd_set = '0;
        for (int i = 0; i < N_CH; i++) begin
            unique case (state_q[i])
                IDLE: begin
                    timer_d[i] = '0;
                    if (synced && act_en[i] && angle_tick &&
                        angle == act_dwell[i] &&
                        act_dwell[i] != act_fire[i]) begin
                        state_d[i] = DWELL;
                    end
                end
                DWELL: begin
                    if (timer_q[i] != LIM) begin
                        timer_d[i] = timer_q[i] + DWELL_W'(1);
                    end
                    // Abort beats spark, spark beats over-dwell.
                    if (!synced || (commit && !sh_en[i])) begin
                        state_d[i] = IDLE;
                        timer_d[i] = '0;
                    end else if (angle_tick && angle == act_fire[i]) begin
                        state_d[i] = IDLE;
                        timer_d[i] = '0;
                    end else if (timer_q[i] == LIM) begin
                        state_d[i] = IDLE;
                        timer_d[i] = '0;
                        ovd_set[i] = 1'b1;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= '{default: IDLE};
            timer_q <= '{default: '0};
            ovd_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ovd_q   <= (ovd_q & ~{N_CH{ovd_clr}}) | ovd_set;
        end
    end

    always_comb begin
        ign = '0;
        for (int i = 0; i < N_CH; i++) begin
            ign[i] = (state_q[i] == DWELL);
        end
    end

    assign overdwell      = ovd_q;
    assign commit_pending = pend_q;

endmodule
